// File: rtl/pipe_skid_reg.sv
// Two-entry skid register slice: main + skid data registers steered by an EMPTY/BUSY/FULL FSM.
// Optional macro PIPE_SKID_STATS_EN adds a saturating 16-bit stall counter port (stall_cnt).
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > 128) begin : g_width_check
            $error("pipe_skid_reg: WIDTH must be in 1..128");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    load_main  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire && !out_ready) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = BUSY;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over any simultaneous transfer; data registers are left untouched.
        if (flush) begin
            state_next     = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Handshake outputs decode from the state register only, so in_ready has no path from out_ready.
    always_comb begin
        in_ready  = (state_reg != FULL);
        out_valid = (state_reg != EMPTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_reg <= RESET_VAL;
            skid_reg <= RESET_VAL;
        end else begin
            if (load_main) begin
                main_reg <= main_from_skid ? skid_reg : in_data;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

    assign out_data = main_reg;

`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (flush) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (WIDTH=8, RESET_VAL=0).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_pipe_skid_reg;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks;
    int errors;

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); errors++; end
        checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", in_ready); errors++; end
        checks++; if (out_data !== 8'h00) begin $display("FAIL reset_out_data got %h want 00", out_data); errors++; end
        reset = 1'b0;
        $display("test_reset: held reset, outputs idle");
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin $display("FAIL async_pre got v=%b d=%h want v=1 d=3c", out_valid, out_data); errors++; end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin $display("FAIL async_reset got v=%b r=%b d=%h want v=0 r=1 d=00", out_valid, in_ready, out_data); errors++; end
        step();
        reset = 1'b0;
        $display("test_async_reset: mid-cycle reset cleared outputs");
    endtask

    task automatic test_stream();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        out_ready = 1'b1; in_valid = 1'b1; in_data = vals[0];
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1) begin $display("FAIL stream_%0d got v=%b d=%h r=%b want v=1 d=%h r=1", i, out_valid, out_data, in_ready, vals[i]); errors++; end
            $display("test_stream: beat %0d out=%h", i, out_data);
            if (i < 2) in_data = vals[i+1];
            else in_valid = 1'b0;
        end
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL stream_drain got v=%b want 0", out_valid); errors++; end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
        step();
        checks++; if (out_data !== 8'hA1 || in_ready !== 1'b1) begin $display("FAIL skid_busy got d=%h r=%b want d=a1 r=1", out_data, in_ready); errors++; end
        in_data = 8'hA2;
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA1) begin $display("FAIL skid_full got r=%b v=%b d=%h want r=0 v=1 d=a1", in_ready, out_valid, out_data); errors++; end
        in_data = 8'hA3;
        step();
        checks++; if (out_data !== 8'hA1 || in_ready !== 1'b0) begin $display("FAIL skid_hold got d=%h r=%b want d=a1 r=0", out_data, in_ready); errors++; end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA2 || in_ready !== 1'b1) begin $display("FAIL skid_second got v=%b d=%h r=%b want v=1 d=a2 r=1", out_valid, out_data, in_ready); errors++; end
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL skid_drain got v=%b want 0", out_valid); errors++; end
        $display("test_skid: A1 then A2 delivered after backpressure");
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1;
        step();
        in_data = 8'hB2;
        step();
        flush = 1'b1; in_data = 8'h55;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'hB1) begin $display("FAIL flush_full got v=%b r=%b d=%h want v=0 r=1 d=b1", out_valid, in_ready, out_data); errors++; end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_no55 got v=%b d=%h want v=0", out_valid, out_data); errors++; end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
        step();
        flush = 1'b1; in_data = 8'h66; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'hC1) begin $display("FAIL flush_busy got v=%b d=%h want v=0 d=c1", out_valid, out_data); errors++; end
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'hC1) begin $display("FAIL idle_hold got v=%b d=%h want v=0 d=c1", out_valid, out_data); errors++; end
        $display("test_flush: flush squashed FULL and BUSY entries");
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
        step();
        in_data = 8'hD2;
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin $display("FAIL reset_full got v=%b r=%b d=%h want v=0 r=1 d=00", out_valid, in_ready, out_data); errors++; end
        step();
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h7E; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h7E) begin $display("FAIL reset_refill got v=%b d=%h want v=1 d=7e", out_valid, out_data); errors++; end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_discard got v=%b d=%h want v=0", out_valid, out_data); errors++; end
        $display("test_reset_full: reset discarded D1/D2, 7E passed");
    endtask

`ifdef PIPE_SKID_STATS_EN
    task automatic test_stats();
        checks++; if (stall_cnt !== 16'd0) begin $display("FAIL stats_init got %h want 0000", stall_cnt); errors++; end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (stall_cnt !== 16'd3) begin $display("FAIL stats_three got %h want 0003", stall_cnt); errors++; end
        for (int i = 0; i < 70000; i++) step();
        checks++; if (stall_cnt !== 16'hFFFF) begin $display("FAIL stats_sat got %h want ffff", stall_cnt); errors++; end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin $display("FAIL stats_flush got c=%h v=%b want c=0000 v=0", stall_cnt, out_valid); errors++; end
        $display("test_stats: saturated then cleared");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_async_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_full();
`ifdef PIPE_SKID_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
